nibble_serial_sub: RTL and testbench

NIBBLE_SERIAL_SUB -- requirements
Module: nibble_serial_sub

---
 rtl/nibble_serial_sub.sv | 147 ++++++++++++++
 tb/tb_nibble_serial_sub.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/nibble_serial_sub.sv
// Serial subtractor: diff = a - b - bin, computed one nibble per clock through a
// 4-bit carry-lookahead slice, least-significant nibble first.
module nibble_serial_sub #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   bin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   diff,
    output logic                   bout,
    output logic                   ovf,
    output logic                   zero
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    shadow_q, shadow_d;
    logic [W-1:0]    diff_q, diff_d;
    logic            bout_q, bout_d;
    logic            ovf_q, ovf_d;
    logic            zero_q, zero_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [3:0]      nib_a, nib_nb, p, g, s;
    logic [4:0]      c;
    logic [W-1:0]    shadow_next;
    logic            last;

    // Operand registers shift right each RUN cycle, so the slice always sees nibble 0.
    always_comb begin
        nib_a  = a_q[3:0];
        nib_nb = ~b_q[3:0];
        p      = nib_a ^ nib_nb;
        g      = nib_a & nib_nb;
        c[0]   = carry_q;
        c[1]   = g[0] | (p[0] & c[0]);
        c[2]   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3]   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & c[0]);
        c[4]   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);
        s      = p ^ c[3:0];
    end

    // New result nibble enters at the top; after NIBBLES shifts the word is aligned.
    assign shadow_next = (shadow_q >> 4) | (W'(s) << (W - 4));
    assign last        = (cnt_q == CW'(NIBBLES - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        shadow_d = shadow_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    carry_d  = ~bin;
                    cnt_d    = '0;
                    shadow_d = '0;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_d      = a_q >> 4;
                b_d      = b_q >> 4;
                carry_d  = c[4];
                shadow_d = shadow_next;
                cnt_d    = cnt_q + CW'(1);
                if (last) begin
                    // On the last nibble a_q[3]/b_q[3] are the operands' sign bits.
                    diff_d  = shadow_next;
                    bout_d  = ~c[4];
                    ovf_d   = (a_q[3] != b_q[3]) && (shadow_next[W-1] != a_q[3]);
                    zero_d  = (shadow_next == '0);
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            shadow_q <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            shadow_q <= shadow_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Directed bench for nibble_serial_sub (NIBBLES=4): latency, busy/done timing,
// borrow/overflow/zero flags, start-while-busy, back-to-back start and reset abort.
module tb_nibble_serial_sub;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;
  logic         zero;

  int n_assert = 0;
  int n_fail   = 0;

  // Last published result, tracked by the bench for the hold checks.
  logic [W-1:0] held_diff;
  logic         held_bout, held_ovf, held_zero;

  nibble_serial_sub #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_held(input string tag);
    check({tag, "_busy"}, W'(busy), W'(1'b1));
    check({tag, "_done"}, W'(done), W'(1'b0));
    check({tag, "_diff_hold"}, diff, held_diff);
    check({tag, "_bout_hold"}, W'(bout), W'(held_bout));
  endtask

  // Called at a negedge; start is applied for the next rising edge (edge T).
  // Returns at the negedge after edge T+4 with done checked high.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tbin, input logic inject,
                        input logic [W-1:0] ed, input logic eb, input logic eo, input logic ez);
    start = 1'b1; a = ta; b = tb; bin = tbin;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom_range(0, 65535));
    b = W'($urandom_range(0, 65535));
    bin = 1'($urandom_range(0, 1));
    check_held({tag, "_T0"});
    for (int i = 1; i < 4; i++) begin
      if (inject && i == 1) begin
        start = 1'b1; a = 16'hFFFF; b = 16'h0000; bin = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      check_held($sformatf("%s_T%0d", tag, i));
    end
    start = 1'b0;
    @(negedge clk);
    check({tag, "_done"}, W'(done), W'(1'b1));
    check({tag, "_busy_low"}, W'(busy), W'(1'b0));
    check({tag, "_diff"}, diff, ed);
    check({tag, "_bout"}, W'(bout), W'(eb));
    check({tag, "_ovf"}, W'(ovf), W'(eo));
    check({tag, "_zero"}, W'(zero), W'(ez));
    held_diff = ed; held_bout = eb; held_ovf = eo; held_zero = ez;
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, W'(done), W'(1'b0));
    check({tag, "_idle_busy"}, W'(busy), W'(1'b0));
    check({tag, "_diff_hold"}, diff, held_diff);
    check({tag, "_ovf_hold"}, W'(ovf), W'(held_ovf));
    check({tag, "_zero_hold"}, W'(zero), W'(held_zero));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    held_diff = '0; held_bout = 1'b0; held_ovf = 1'b0; held_zero = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", W'(busy), W'(1'b0));
    check("rst_done", W'(done), W'(1'b0));
    check("rst_diff", diff, 16'h0000);
    check("rst_flags", W'({bout, ovf, zero}), W'(3'b000));
    rst = 1'b0;
    @(negedge clk);

    run_op("basic", 16'h1234, 16'h0034, 1'b0, 1'b0, 16'h1200, 1'b0, 1'b0, 1'b0);
    idle_cycle("basic_post");
    run_op("underflow", 16'h0000, 16'h0001, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    idle_cycle("underflow_post");
    run_op("overflow", 16'h8000, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    idle_cycle("overflow_post");
    run_op("bin_zero", 16'h5A5A, 16'h5A59, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    idle_cycle("bin_zero_post");

    // Start during RUN must be ignored; start in the done cycle must be accepted.
    run_op("ignore_start", 16'h0010, 16'h0001, 1'b0, 1'b1, 16'h000F, 1'b0, 1'b0, 1'b0);
    run_op("back_to_back", 16'h0003, 16'h0005, 1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0);
    idle_cycle("b2b_post");

    // Reset during the second RUN cycle aborts the operation.
    start = 1'b1; a = 16'h1111; b = 16'h0001; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    held_diff = '0; held_bout = 1'b0; held_ovf = 1'b0; held_zero = 1'b0;
    check("abort_busy", W'(busy), W'(1'b0));
    check("abort_done", W'(done), W'(1'b0));
    check("abort_diff", diff, 16'h0000);
    check("abort_flags", W'({bout, ovf, zero}), W'(3'b000));
    for (int i = 0; i < 4; i++) idle_cycle($sformatf("abort_wait%0d", i));
    run_op("after_rst", 16'h0002, 16'h0001, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0);
    idle_cycle("after_rst_post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
